// File: rtl/seq_pkg.sv
// seq_pkg: definitions shared by the serial pattern generator and the
// matching pattern detector, so both sides agree on one pattern.
//   seq_state_e  generator FSM state encoding (2 bits)
//   SEQ_PAT_W    width of the default pattern
//   SEQ_PATTERN  default pattern, MSB transmitted first
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  localparam int                   SEQ_PAT_W   = 5;
  localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN = 5'b11011;

endpackage

// File: rtl/seq_gen_if.sv
// seq_gen_if: request and serial-output signals of the pattern generator.
//   start     request, sampled only while the generator is idle
//   frames    number of frames to send, latched with start
//   gap_len   idle bit-times between frames, latched with start
//   bit_en    bit-rate strobe
//   tx_bit    serial data
//   tx_valid  tx_bit carries a pattern bit
//   busy      request in progress
//   done      one-cycle completion pulse
// Modports: master = requester / stimulus side, slave = generator.
interface seq_gen_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);

  logic             start;
  logic [CNT_W-1:0] frames;
  logic [GAP_W-1:0] gap_len;
  logic             bit_en;
  logic             tx_bit;
  logic             tx_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, frames, gap_len, bit_en,
    input  tx_bit, tx_valid, busy, done
  );

  modport slave (
    input  start, frames, gap_len, bit_en,
    output tx_bit, tx_valid, busy, done
  );

endinterface

// File: rtl/seq_gen_cnt.sv
// seq_gen_cnt: loadable down-counter used for the bit index, frame count
// and gap count of the pattern generator.
//   clk, rst_n  clock and asynchronous active-low reset (count clears to 0)
//   load        load load_val (has priority over dec)
//   load_val    value to load
//   dec         decrement by one; ignored at zero so the count never wraps
//   q           current count
//   zero        count is zero
module seq_gen_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] q,
  output logic         zero
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q    = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial pattern generator. On an accepted start it sends PATTERN
// MSB-first for the latched number of frames, with the latched number of
// idle bit-times between frames. SEND and GAP advance only on bit_en.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         seq_gen_if slave: start/frames/gap_len/bit_en in,
//               tx_bit/tx_valid/busy/done out (all registered)
module seq_gen
  import seq_pkg::*;
#(
  parameter int             PAT_W   = SEQ_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = SEQ_PATTERN,
  parameter int             CNT_W   = 8,
  parameter int             GAP_W   = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_gen_if.slave bus
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  seq_state_e       state_d, state_q;
  logic [GAP_W-1:0] gap_len_d, gap_len_q;
  logic             tx_bit_d, tx_bit_q;
  logic             tx_valid_d, tx_valid_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;

  logic             idx_load, idx_dec, idx_zero;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic             frm_load, frm_dec, frm_zero;
  logic [CNT_W-1:0] frm_q;
  logic             gap_load, gap_dec, gap_zero;
  logic [GAP_W-1:0] gap_q;
  logic             frm_more;
  logic             gap_end;

  seq_gen_cnt #(.W(IDX_W)) u_idx_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (idx_load),
    .load_val (IDX_LAST),
    .dec      (idx_dec),
    .q        (idx_q),
    .zero     (idx_zero)
  );

  seq_gen_cnt #(.W(CNT_W)) u_frm_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (frm_load),
    .load_val (bus.frames),
    .dec      (frm_dec),
    .q        (frm_q),
    .zero     (frm_zero)
  );

  seq_gen_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (gap_len_q),
    .dec      (gap_dec),
    .q        (gap_q),
    .zero     (gap_zero)
  );

  // The frame counter holds the frames still to send, including the current
  // one, so "more to come" means a count above one. The gap counter is
  // loaded with gap_len and the gap ends on the strobe that takes it to 0.
  assign frm_more = !frm_zero && (frm_q != CNT_W'(1));
  assign gap_end  = gap_zero || (gap_q == GAP_W'(1));

  // Next-state and counter control. Terminal conditions are checked on the
  // current count before any decrement.
  always_comb begin
    state_d   = state_q;
    gap_len_d = gap_len_q;
    idx_load  = 1'b0;
    idx_dec   = 1'b0;
    frm_load  = 1'b0;
    frm_dec   = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          gap_len_d = bus.gap_len;
          frm_load  = 1'b1;
          if (bus.frames == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_SEND;
            idx_load = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (bus.bit_en) begin
          if (!idx_zero) begin
            idx_dec = 1'b1;
          end else if (frm_more) begin
            frm_dec = 1'b1;
            if (gap_len_q != '0) begin
              state_d  = ST_GAP;
              gap_load = 1'b1;
            end else begin
              idx_load = 1'b1;
            end
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_GAP: begin
        if (bus.bit_en) begin
          gap_dec = 1'b1;
          if (gap_end) begin
            state_d  = ST_SEND;
            idx_load = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The outputs are registered from the next state, so the bit shown next
  // cycle needs the bit index the counter is about to hold.
  always_comb begin
    idx_nxt = idx_q;
    if (idx_load) begin
      idx_nxt = IDX_LAST;
    end else if (idx_dec) begin
      idx_nxt = idx_q - IDX_W'(1);
    end
    tx_valid_d = (state_d == ST_SEND);
    tx_bit_d   = (state_d == ST_SEND) && PATTERN[idx_nxt];
    busy_d     = (state_d == ST_SEND) || (state_d == ST_GAP);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gap_len_q  <= '0;
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_len_q  <= gap_len_d;
      tx_bit_q   <= tx_bit_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.tx_bit   = tx_bit_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: self-checking bench for seq_gen. A table of per-cycle
// {inputs, expected outputs} records covers single and multi-frame requests;
// hand-written sequences cover the slow strobe, zero frames, ignored starts,
// asynchronous reset mid-request and a loopback into a detector model.
module tb_seq_gen;

  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  typedef struct packed {
    logic             start;
    logic [CNT_W-1:0] frames;
    logic [GAP_W-1:0] gap_len;
    logic             bit_en;
    logic             exp_bit;
    logic             exp_valid;
    logic             exp_busy;
    logic             exp_done;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs[$];
  logic [4:0] pat;

  seq_gen_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  seq_gen #(
    .PAT_W   (5),
    .PATTERN (5'b11011),
    .CNT_W   (CNT_W),
    .GAP_W   (GAP_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic st, input int fr, input int gl, input logic en,
                              input logic b, input logic v, input logic bz, input logic d);
    vec_t r;
    r.start     = st;
    r.frames    = CNT_W'(fr);
    r.gap_len   = GAP_W'(gl);
    r.bit_en    = en;
    r.exp_bit   = b;
    r.exp_valid = v;
    r.exp_busy  = bz;
    r.exp_done  = d;
    return r;
  endfunction

  task automatic checkOne(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic e_bit, input logic e_valid,
                             input logic e_busy, input logic e_done);
    checkOne({tag, ".tx_bit"},   bus.tx_bit,   e_bit);
    checkOne({tag, ".tx_valid"}, bus.tx_valid, e_valid);
    checkOne({tag, ".busy"},     bus.busy,     e_busy);
    checkOne({tag, ".done"},     bus.done,     e_done);
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic st, input int fr, input int gl, input logic en);
    bus.start   = st;
    bus.frames  = CNT_W'(fr);
    bus.gap_len = GAP_W'(gl);
    bus.bit_en  = en;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int done_cnt;
    int valid_cnt;
    int done_cyc;
    int det_cnt;
    logic [4:0] sr;

    checks      = 0;
    failures    = 0;
    pat         = 5'b11011;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.frames  = '0;
    bus.gap_len = '0;
    bus.bit_en  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Row k: inputs during cycle k, outputs expected in cycle k+1.
    // frames=1, gap_len=0.
    vecs.push_back(mk(1, 1, 0, 1,  1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1,  0, 0, 0, 0));
    // frames=2, gap_len=2; inputs change after start to show they are latched.
    vecs.push_back(mk(1, 2, 2, 1,  1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1,  1, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1,  0, 0, 0, 1));
    vecs.push_back(mk(1, 2, 0, 1,  0, 0, 0, 0));
    vecs.push_back(mk(0, 2, 0, 1,  0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].start, int'(vecs[i].frames), int'(vecs[i].gap_len), vecs[i].bit_en);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_bit, vecs[i].exp_valid,
                  vecs[i].exp_busy, vecs[i].exp_done);
    end

    // bit_en every third cycle: each bit is held three cycles.
    for (int k = 0; k <= 16; k++) begin
      int c;
      applyStimulus(k == 0, 1, 0, (k >= 1) && (k % 3 == 0));
      c = k + 1;
      if (c <= 15) begin
        checkOutput($sformatf("slow_c%0d", c), pat[4 - (c - 1) / 3], 1'b1, 1'b1, 1'b0);
      end else if (c == 16) begin
        checkOutput("slow_done", 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        checkOutput("slow_idle", 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    // frames=0 completes at once without any valid bit.
    applyStimulus(1'b1, 0, 3, 1'b1);
    checkOutput("zero_frames", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 3, 1'b1);
    checkOutput("zero_frames_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // A start pulse in the middle of a request is ignored.
    done_cnt  = 0;
    valid_cnt = 0;
    done_cyc  = -1;
    for (int k = 0; k < 12; k++) begin
      applyStimulus((k == 0) || (k == 3), 1, 0, 1'b1);
      if (bus.tx_valid) valid_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = k + 1;
      end
    end
    checkCount("ignored_start.done_count", done_cnt, 1);
    checkCount("ignored_start.valid_count", valid_cnt, 5);
    checkCount("ignored_start.done_cycle", done_cyc, 6);

    // Reset during frame 2 aborts at once with no done afterwards.
    for (int k = 0; k <= 8; k++) begin
      applyStimulus(k == 0, 3, 0, 1'b1);
    end
    checkOutput("pre_reset", 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt  = 0;
    valid_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 3, 0, 1'b1);
      if (bus.done) done_cnt++;
      if (bus.tx_valid) valid_cnt++;
    end
    checkCount("after_reset.done_count", done_cnt, 0);
    checkCount("after_reset.valid_count", valid_cnt, 0);
    for (int k = 0; k <= 6; k++) begin
      int c;
      applyStimulus(k == 0, 1, 0, 1'b1);
      c = k + 1;
      if (c <= 5) begin
        checkOutput($sformatf("restart_c%0d", c), pat[5 - c], 1'b1, 1'b1, 1'b0);
      end else if (c == 6) begin
        checkOutput("restart_done", 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        checkOutput("restart_idle", 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    // Loopback into an overlapping 11011 detector model, back-to-back frames.
    sr       = '0;
    det_cnt  = 0;
    done_cnt = 0;
    done_cyc = -1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(k == 0, 3, 0, 1'b1);
      if (bus.tx_valid) begin
        sr = {sr[3:0], bus.tx_bit};
        if (sr == 5'b11011) det_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = k + 1;
      end
    end
    checkCount("loopback.detections", det_cnt, 3);
    checkCount("loopback.done_count", done_cnt, 1);
    checkCount("loopback.done_cycle", done_cyc, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern generator: on a start request it transmits a fixed PAT_W-bit pattern (default 11011) MSB-first for a programmable number of frames, with a programmable idle gap between frames. It is the transmit-side counterpart to the team's serial pattern detector and drives detector inputs in loopback test and on-chip stimulus paths. The bit rate is set by an external bit-enable strobe.

## Interface
- PAT_W, 5, pattern length in bits (≥2)
- PATTERN, 5'b11011, pattern bits, bit PAT_W-1 sent first
- CNT_W, 8, width of the frame-count input
- GAP_W, 4, width of the gap-length input
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- frames  in  CNT_W  number of frames to send; latched with start
- gap_len  in  GAP_W  idle bit-times between frames; latched with start
- bit_en  in  1  bit-rate strobe; SEND/GAP advance only when high
- tx_bit  out  1  serial data, registered
- tx_valid  out  1  high while tx_bit carries a pattern bit
- busy  out  1  high from the cycle after start is accepted through the last bit
- done  out  1  one-cycle pulse when the request completes

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE: busy=0, tx_valid=0, tx_bit=0. If start=1, latch frames and gap_len. Go to SEND with bit index PAT_W-1 and frame counter=frames. If frames=0, go directly to DONE.
- SEND: tx_bit=PATTERN[idx], tx_valid=1. On bit_en:
  - idx>0: decrement idx.
  - idx=0 with frames remaining >1: decrement the frame counter. Go to GAP if gap_len≠0, else back to SEND with idx=PAT_W-1 (back-to-back frames).
  - idx=0 on the last frame: go to DONE.
- GAP: tx_bit=0, tx_valid=0, busy=1. Load the gap counter with gap_len on entry. Decrement on each bit_en. When it reaches 0, go to SEND with idx=PAT_W-1.
- DONE: done=1, busy=0, tx_valid=0 for exactly one cycle, then IDLE. Unconditional; bit_en is not needed.
- start while busy or in DONE is ignored. No queuing.
- When bit_en=0, SEND/GAP hold all state and outputs.
- A latched frames/gap_len value does not change mid-request, even if the inputs change.
- Counters use plain unsigned arithmetic and never wrap. Terminal conditions are tested before decrement.
- Maximum request: 2^CNT_W−1 frames.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE; tx_bit=0, tx_valid=0, busy=0, done=0; all counters 0.
- Reset asserted mid-request aborts immediately. No done pulse follows.
- All outputs are registered; there are no combinational input→output paths.
- start accepted at edge t: tx_bit/tx_valid show the first pattern bit from cycle t+1.
- Each bit is held until the first bit_en edge after it appears. With bit_en=1 constantly, one bit per cycle.
- Last bit consumed at edge u: done=1 during cycle u+1, IDLE at u+2. A new start is accepted at u+2 at the earliest.
- Total cycles at bit_en=1: frames·PAT_W + (frames−1)·gap_len, then 1 DONE cycle.

## Structure
- Shared package seq_pkg holds:
  - the state enum (IDLE/SEND/GAP/DONE, 2-bit encoding);
  - the default pattern constant 5'b11011 and its width, so generator and detector use one definition.
- Sub-module seq_gen_cnt: a loadable down-counter (load, dec, zero flag), parameterized width. Instantiated for the bit index, frame count and gap count.
- Top-level FSM and output registers stay in seq_gen.

## Test plan
- frames=1, gap_len=0, bit_en=1, start at cycle 0 → tx_bit 1,1,0,1,1 with tx_valid=1 on cycles 1–5; done=1 on cycle 6; busy=1 on cycles 1–5 only.
- frames=2, gap_len=2 → bits on cycles 1–5 and 8–12; tx_valid=0 and tx_bit=0 on cycles 6–7; done on cycle 13.
- bit_en high every 3rd cycle → each bit held 3 cycles; sequence and done ordering are unchanged.
- frames=0 → done on cycle 1; tx_valid never asserts. Also pulse start on cycle 3 of an active request → ignored; exactly one done.
- rst_n low during frame 2, bit 3 → all outputs 0 immediately; no done. After release, a fresh start at frames=1 produces the full 11011.
- Loopback into the 11011 detector with frames=3, gap_len=0 → detector flags exactly 3 detections, one per frame, given overlap.
